// File: rtl/ttl_74f259_sync.sv
// Clocked 74F259 8-bit addressable latch: one data bit per edge into Q[{C,B,A}].
// Optional combinational readback port R is enabled by TTL_74F259_READBACK_EN.
module ttl_74f259_sync #(
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       D,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       G,
  input  logic       CLR,
  output logic [7:0] Q,
`ifdef TTL_74F259_READBACK_EN
  output logic       WR,
  output logic       R
`else
  output logic       WR
`endif
);

  localparam int unsigned W     = 8;
  localparam int unsigned SEL_W = 3;

  logic [SEL_W-1:0] sel;
  logic [W-1:0]     q_d, q_q;
  logic             chg_d, chg_q;
  logic             wr_q;

  assign sel = {C, B, A};

  // Mode decode from {CLR,G}: latch, memory, demux, clear.
  always_comb begin
    q_d = q_q;
    case ({CLR, G})
      2'b10: q_d[sel] = D;
      2'b11: q_d = q_q;
      2'b00: begin
        q_d      = '0;
        q_d[sel] = D;
      end
      2'b01: q_d = '0;
      default: q_d = q_q;
    endcase
  end

  assign chg_d = (q_d != q_q);

  // chg_q marks the edge where Q moved; WR is that flag delayed one more edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q   <= RESET_VAL;
      chg_q <= 1'b0;
      wr_q  <= 1'b0;
    end else begin
      q_q   <= q_d;
      chg_q <= chg_d;
      wr_q  <= chg_q;
    end
  end

  assign Q  = q_q;
  assign WR = wr_q;

`ifdef TTL_74F259_READBACK_EN
  assign R = q_q[sel];
`endif

endmodule
